irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that is the request-side partner of the CP0 unit. It collects `NUM_SRC` peripheral interrupt lines, latches rising edges as pending, applies a software mask and fixed priority, and sends a single-cycle request pulse to CP0's external interrupt input. It then stays in service until CP0 signals ERET, so requests are not nested, matching CP0's no-reentry rule. It sits on the CPU data bus beside the other peripherals.

---
 rtl/irq_defs.sv | 37 +++
 rtl/irq_prio_enc.sv | 29 ++
 rtl/irq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_defs.sv
// -----------------------------------------------------------------------------
// irq_defs -- shared definitions for the interrupt controller.
//
// Contents:
//   IRQ_PEND / IRQ_MASK / IRQ_CAUSE / IRQ_CTRL : register word offsets
//                                                (data address bits [3:2])
//   CTRL_GEN                                    : global-enable bit in CTRL
//   CAUSE_BUSY                                  : busy flag bit in CAUSE
//   irq_state_t (IRQ_IDLE, IRQ_BUSY)            : dispatch FSM states
//   cause_word()                                : packs the CAUSE read value
// -----------------------------------------------------------------------------
package irq_defs;

   localparam logic [1:0] IRQ_PEND  = 2'd0;
   localparam logic [1:0] IRQ_MASK  = 2'd1;
   localparam logic [1:0] IRQ_CAUSE = 2'd2;
   localparam logic [1:0] IRQ_CTRL  = 2'd3;

   localparam int CTRL_GEN   = 0;
   localparam int CAUSE_BUSY = 31;

   typedef enum logic {
      IRQ_IDLE = 1'b0,
      IRQ_BUSY = 1'b1
   } irq_state_t;

   // CAUSE layout: bit 31 = busy, bits [3:0] = id of the serviced source.
   function automatic logic [31:0] cause_word(input logic busy_bit,
                                              input logic [3:0] id);
      logic [31:0] w;
      w             = 32'd0;
      w[CAUSE_BUSY] = busy_bit;
      w[3:0]        = id;
      return w;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc -- combinational fixed-priority encoder, lowest index wins.
//
// Ports:
//   req   in  W   request vector (already masked by the caller)
//   valid out 1   at least one request bit is set
//   id    out 4   index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
   parameter int W = 8
) (
   input  logic [W-1:0] req,
   output logic         valid,
   output logic [3:0]   id
);

   // Scan from the top down so the last hit, i.e. the lowest index, sticks.
   always_comb begin
      valid = 1'b0;
      id    = 4'd0;
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = 4'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller feeding CP0's external
// interrupt input.
//
// Rising edges on src_in are latched in PEND. While idle and globally
// enabled, the lowest-index pending-and-unmasked source is dispatched: its id
// goes to CAUSE, its PEND bit is cleared and ir_out pulses for one cycle. The
// controller then stays busy (no further dispatch) until CP0 reports ERET.
//
// Ports:
//   clk        in  1        main clock
//   rst        in  1        asynchronous active-high reset
//   src_in     in  NUM_SRC  peripheral request lines (edge-sensitive, clk-sync)
//   eret       in  1        one-cycle pulse when CP0 executes ERET
//   bus_addr   in  2        register word select
//   bus_we     in  1        write strobe (already chip-select qualified)
//   bus_wdata  in  32       write data
//   bus_rdata  out 32       read data, combinational from bus_addr
//   ir_out     out 1        registered one-cycle request pulse to CP0
//   busy       out 1        a dispatched interrupt is in service
//
// Register map (word offsets):
//   0 PEND  [NUM_SRC-1:0] pending edges, write 1 to clear
//   1 MASK  [NUM_SRC-1:0] 1 enables the source
//   2 CAUSE [31] busy, [3:0] serviced id (read-only)
//   3 CTRL  [0] GEN global enable
// -----------------------------------------------------------------------------
module irq_ctrl
   import irq_defs::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic               eret,
   input  logic [1:0]         bus_addr,
   input  logic               bus_we,
   input  logic [31:0]        bus_wdata,
   output logic [31:0]        bus_rdata,
   output logic               ir_out,
   output logic               busy
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] mask;
   logic               gen;
   logic [3:0]         cause_id;
   irq_state_t         state;
   irq_state_t         state_nxt;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic [NUM_SRC-1:0] edges;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] disp_clr;
   logic [NUM_SRC-1:0] pend_nxt;
   logic               win_valid;
   logic [3:0]         win_id;
   logic               dispatch;
   logic               wr_pend;
   logic               wr_mask;
   logic               wr_ctrl;
   logic               wdata_unused;

   // Only the low NUM_SRC bits (and bit 0 for CTRL) of a write carry data.
   assign wdata_unused = ^bus_wdata;

   assign edges = src_in & ~src_q;
   assign req   = pend & mask;

   assign wr_pend = bus_we && (bus_addr == IRQ_PEND);
   assign wr_mask = bus_we && (bus_addr == IRQ_MASK);
   assign wr_ctrl = bus_we && (bus_addr == IRQ_CTRL);

   irq_prio_enc #(
      .W(NUM_SRC)
   ) u_prio_enc (
      .req   (req),
      .valid (win_valid),
      .id    (win_id)
   );

   // ---------------------------------------------------------------------
   // Dispatch FSM, next-state half. The decision looks only at the current
   // MASK/GEN/PEND registers, so a bus write in the same cycle affects the
   // following decision, never this one.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      dispatch  = 1'b0;
      case (state)
         IRQ_IDLE: begin
            if (gen && win_valid) begin
               dispatch  = 1'b1;
               state_nxt = IRQ_BUSY;
            end
         end
         IRQ_BUSY: begin
            // The pending set is re-evaluated from IDLE on the next edge, so
            // nothing that arrived during service is lost.
            if (eret) begin
               state_nxt = IRQ_IDLE;
            end
         end
         default: begin
            state_nxt = IRQ_IDLE;
         end
      endcase
   end

   // One-hot clear for the dispatched source; built by comparison so the
   // 4-bit id never indexes past a narrow PEND.
   always_comb begin
      disp_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         disp_clr[i] = dispatch && (win_id == 4'(i));
      end
   end

   assign w1c = wr_pend ? bus_wdata[NUM_SRC-1:0] : '0;

   // Clears first, then new edges OR in, so an edge always survives a
   // same-cycle W1C. An edge on an already-set bit simply leaves it set.
   assign pend_nxt = (pend & ~disp_clr & ~w1c) | edges;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IRQ_IDLE;
         src_q    <= '0;
         pend     <= '0;
         mask     <= '0;
         gen      <= 1'b0;
         cause_id <= 4'd0;
         ir_out   <= 1'b0;
      end else begin
         state  <= state_nxt;
         src_q  <= src_in;
         pend   <= pend_nxt;
         ir_out <= dispatch;
         if (wr_mask) begin
            mask <= bus_wdata[NUM_SRC-1:0];
         end
         if (wr_ctrl) begin
            gen <= bus_wdata[CTRL_GEN];
         end
         // CAUSE keeps the last serviced id after returning to IDLE.
         if (dispatch) begin
            cause_id <= win_id;
         end
      end
   end

   assign busy = (state == IRQ_BUSY);

   // ---------------------------------------------------------------------
   // Read mux, zero-latency
   // ---------------------------------------------------------------------
   always_comb begin
      bus_rdata = 32'd0;
      case (bus_addr)
         IRQ_PEND:  bus_rdata[NUM_SRC-1:0] = pend;
         IRQ_MASK:  bus_rdata[NUM_SRC-1:0] = mask;
         IRQ_CAUSE: bus_rdata              = cause_word(busy, cause_id);
         IRQ_CTRL:  bus_rdata[CTRL_GEN]    = gen;
         default:   bus_rdata              = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl (NUM_SRC = 8).
// A behavioural model predicts each request pulse and pushes
// {cycle, id} into exp_q; a negedge monitor pops it when ir_out is seen.
// Register reads and busy are checked against the model every cycle.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  import irq_defs::*;

  localparam int N  = 8;
  localparam int QW = 36;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic [N-1:0] src_in    = '0;
  logic         eret      = 1'b0;
  logic [1:0]   bus_addr  = IRQ_CAUSE;
  logic         bus_we    = 1'b0;
  logic [31:0]  bus_wdata = 32'd0;
  logic [31:0]  bus_rdata;
  logic         ir_out;
  logic         busy;

  irq_ctrl #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .eret      (eret),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ir_out    (ir_out),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [QW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [N-1:0] m_pend, m_mask, m_src_q;
  logic         m_gen, m_busy, m_last_disp;
  logic [3:0]   m_cause;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_src_q = '0;
    m_gen = 1'b0; m_busy = 1'b0; m_last_disp = 1'b0; m_cause = 4'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_pend};
      2'd1:    return {24'd0, m_mask};
      2'd2:    return {m_busy, 27'd0, m_cause};
      default: return {31'd0, m_gen};
    endcase
  endfunction

  // What happens at the coming posedge given this cycle's inputs.
  task automatic model_step(input logic [N-1:0] s, input logic e, input logic we,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [N-1:0] rising, ready;
    int win;
    rising = s & ~m_src_q;
    ready  = m_pend & m_mask;
    win    = -1;
    if (!m_busy && m_gen)
      for (int i = 0; i < N; i++)
        if (ready[i] && win < 0) win = i;
    if (win >= 0) m_pend[win] = 1'b0;
    if (we && a == 2'd0) m_pend = m_pend & ~wd[N-1:0];
    m_pend = m_pend | rising;
    if (we && a == 2'd1) m_mask = wd[N-1:0];
    if (we && a == 2'd3) m_gen = wd[0];
    m_src_q = s;
    if (win >= 0) begin
      m_busy  = 1'b1;
      m_cause = 4'(win);
      exp_q.push_back({32'(cyc + 1), 4'(win)});
    end else if (m_busy && e) begin
      m_busy = 1'b0;
    end
    m_last_disp = (win >= 0);
  endtask

  // ---------------------------------------------------------------- driver
  // The cycle right after a dispatch keeps the bus on CAUSE so the monitor
  // can read the serviced id while ir_out is high.
  task automatic tick(input logic [N-1:0] s, input logic e, input logic we,
                      input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_busy;
    @(posedge clk);
    #1;
    if (m_last_disp) begin
      we = 1'b0;
      a  = IRQ_CAUSE;
    end
    src_in = s; eret = e; bus_we = we; bus_addr = a; bus_wdata = wd;
    exp_rd   = model_read(a);
    exp_busy = m_busy;
    model_step(s, e, we, a, wd);
    #1;
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check($sformatf("rdata_addr%0d", a), bus_rdata, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(src_in, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    tick(src_in, 1'b0, 1'b1, a, wd);
  endtask

  task automatic rd(input logic [1:0] a);
    tick(src_in, 1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic do_eret();
    tick(src_in, 1'b1, 1'b0, IRQ_CAUSE, 32'd0);
  endtask

  // ---------------------------------------------------------------- monitor
  logic [QW-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst && ir_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ir_pulse: got unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("ir_pulse_cycle", 32'(cyc), mon_e[QW-1:4]);
        if (bus_addr == IRQ_CAUSE)
          check("ir_cause_id", {28'd0, bus_rdata[3:0]}, {28'd0, mon_e[3:0]});
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [N-1:0] rs;
  logic         re, rwe;
  logic [1:0]   ra;
  logic [31:0]  rwd;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    rd(IRQ_PEND); rd(IRQ_MASK); rd(IRQ_CAUSE); rd(IRQ_CTRL);

    // single source, first-dispatch latency
    wr(IRQ_MASK, 32'h01);
    wr(IRQ_CTRL, 32'h01);
    tick(8'h01, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h01, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    rd(IRQ_CAUSE); rd(IRQ_PEND);
    tick(8'h00, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    do_eret(); idle(2);

    // simultaneous edges: priority, then re-dispatch after eret
    wr(IRQ_MASK, 32'hFF);
    tick(8'h24, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h00, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    idle(3); rd(IRQ_PEND);
    do_eret(); idle(3);
    do_eret(); idle(2);

    // masked source stays pending until unmasked
    wr(IRQ_MASK, 32'h00);
    tick(8'h08, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h00, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    rd(IRQ_PEND); idle(2);
    wr(IRQ_MASK, 32'h08);
    idle(2); do_eret(); idle(2);

    // W1C vs edge on the same bit, then W1C alone
    wr(IRQ_MASK, 32'h00);
    tick(8'h10, 1'b0, 1'b1, IRQ_PEND, 32'h10);
    tick(8'h00, 1'b0, 1'b0, IRQ_PEND, 32'd0);
    wr(IRQ_PEND, 32'h10);
    rd(IRQ_PEND);

    // writes in the dispatch cycle use the pre-write MASK/GEN
    wr(IRQ_CTRL, 32'h00);
    wr(IRQ_MASK, 32'h02);
    tick(8'h02, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h00, 1'b0, 1'b1, IRQ_CTRL, 32'h01);
    wr(IRQ_MASK, 32'h00);
    idle(1); rd(IRQ_MASK); do_eret(); idle(2);

    // dispatch clear and W1C of the same bit together
    wr(IRQ_MASK, 32'h02);
    tick(8'h02, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h00, 1'b0, 1'b1, IRQ_PEND, 32'h02);
    idle(1); rd(IRQ_PEND);

    // edges during BUSY only pend; eret with nothing pending from IDLE
    wr(IRQ_MASK, 32'h00);
    tick(8'h81, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h00, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    rd(IRQ_PEND);
    do_eret();
    wr(IRQ_PEND, 32'hFF);
    do_eret(); rd(IRQ_CAUSE); rd(IRQ_PEND);

    // async reset mid-BUSY with PEND = 0x06
    wr(IRQ_MASK, 32'h01);
    tick(8'h07, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    tick(8'h07, 1'b0, 1'b0, IRQ_CAUSE, 32'd0);
    @(posedge clk);
    #7;
    check("pulse_before_rst", {31'd0, ir_out}, 32'd1);
    bus_addr = IRQ_PEND; #1;
    check("pend_before_rst", bus_rdata, 32'h06);
    rst = 1'b1; src_in = '0; eret = 1'b0; bus_we = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ir_out", {31'd0, ir_out}, 32'd0);
    check("rst_pend", bus_rdata, 32'd0);
    bus_addr = IRQ_MASK;  #1; check("rst_mask", bus_rdata, 32'd0);
    bus_addr = IRQ_CAUSE; #1; check("rst_cause", bus_rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // randomized traffic
    wr(IRQ_MASK, 32'hFF);
    wr(IRQ_CTRL, 32'h01);
    for (int k = 0; k < 1500; k++) begin
      rs = src_in;
      if ($urandom_range(0, 2) == 0) rs = rs ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      re  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      rwe = ($urandom_range(0, 4) == 0);
      ra  = 2'($urandom_range(0, 3));
      rwd = $urandom;
      if (ra == IRQ_CTRL) rwd = {31'd0, ($urandom_range(0, 4) != 0)};
      tick(rs, re, rwe, ra, rwd);
    end

    // drain
    for (int k = 0; k < 6; k++) tick(8'h00, 1'b1, 1'b0, IRQ_CAUSE, 32'd0);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL ir_missing: got %0d outstanding expected pulses, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
